fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage feeding the decode stage: owns the PC, issues word reads to instruction memory, and
//  registers the returned 34-bit instruction with its PC into the IF/ID output register. Decode slices fields
//  from if_instr (immediates go to Sign_Extend, In[33:0]). Supports decode back-pressure and branch redirect/flush.
// PARAMETERS
//  INSTR_W   34        instruction width (matches Sign_Extend input)
//  ADDR_W    24        PC / instruction-memory word-address width (datapath width)
//  RESET_PC  24'h0     PC value loaded on reset
// PORTS
//  clk            in   1        system clock, all state on rising edge
//  rst_n          in   1        asynchronous active-low reset
//  imem_req       out  1        one-cycle read request pulse
//  imem_addr      out  ADDR_W   word address, valid while imem_req=1
//  imem_rvalid    in   1        read data valid; in order, >=1 cycle after imem_req
//  imem_rdata     in   INSTR_W  instruction word, valid with imem_rvalid
//  redirect_valid in   1        branch/jump taken: flush and restart fetch
//  redirect_pc    in   ADDR_W   new fetch address, valid with redirect_valid
//  if_valid       out  1        IF/ID register holds a valid instruction
//  if_ready       in   1        decode accepts; transfer when if_valid & if_ready
//  if_instr       out  INSTR_W  fetched instruction
//  if_pc          out  ADDR_W   address of if_instr
//  if_pc_plus1    out  ADDR_W   if_pc + 1, wraps mod 2^ADDR_W
// BEHAVIOUR
//  Reset (async, rst_n=0): pc=RESET_PC, state=IDLE, imem_req=0, imem_addr=0, if_valid=0, if_instr=0,
//   if_pc=0, if_pc_plus1=0. Deassertion is synchronised by the system; first issue no earlier than the first edge after.
//  At most one outstanding memory request. Output register empty or draining: out_free = !if_valid | if_ready.
//  FSM states IDLE, WAIT, DISCARD:
//   IDLE: if !redirect_valid & out_free -> imem_req=1, imem_addr=pc, pc<=pc+1 (wrap), go WAIT.
//         imem_rvalid in IDLE is ignored (stale response after reset).
//   WAIT: on imem_rvalid -> if_instr<=imem_rdata, if_pc<=issued addr, if_pc_plus1<=addr+1, if_valid<=1, go IDLE.
//   DISCARD: on imem_rvalid -> drop data, go IDLE. No issue while in DISCARD.
//  Issue only when out_free guarantees the output register is empty at response time; no skid buffer.
//   Peak throughput with 1-cycle memory: one instruction per 2 cycles.
//  Handshake: if_valid & if_ready clears if_valid next edge unless a response loads it the same edge.
//   While if_valid & !if_ready, if_instr/if_pc/if_pc_plus1 are held stable.
//  Redirect (highest priority, any state): pc<=redirect_pc, if_valid<=0, no imem_req that cycle.
//   In WAIT without same-cycle rvalid -> DISCARD. In WAIT with same-cycle rvalid -> data dropped, IDLE.
//   In DISCARD -> stays DISCARD, pc updated. In IDLE -> stays IDLE, next cycle issues redirect_pc.
//  Back-to-back redirects: last one wins.
//  PC wrap: pc=2^ADDR_W-1 issues, then pc=0. if_pc_plus1 wraps identically.
//  Reset mid-WAIT: FSM returns to IDLE. The in-flight response is then ignored per the IDLE rule.
// STRUCTURE
//  Shared package proc_pkg: INSTR_W, ADDR_W, RESET_PC constants; fetch_state_t enum {IDLE, WAIT, DISCARD}.
//  One sub-module, pc_register: ADDR_W flop with async active-low reset to RESET_PC, load (redirect) and
//   increment (issue) enables, load priority. FSM, issued-address latch and IF/ID register stay in fetch_stage.
// TESTING
//  1 Reset: rst_n=0 mid-run -> all outputs 0 immediately; release -> first imem_req with addr 24'h000000.
//  2 Stream, 1-cycle mem, if_ready=1: rdata=34'h0000000C,34'h3333_3333 -> if_pc 0,1;
//    if_pc_plus1 1,2; imem_req every 2nd cycle.
//  3 Stall: if_ready=0 for 5 cycles with if_valid=1 -> outputs constant, no imem_req; if_ready=1 -> next issue same cycle.
//  4 Redirect in WAIT, rdata arrives 3 cycles later: redirect_pc=24'h000100 -> response dropped, if_valid stays 0;
//    next req addr 24'h000100.
//  5 Redirect same cycle as imem_rvalid, and same cycle as an IDLE issue -> data dropped / no req;
//    next req at redirect_pc.
//  6 Wrap: redirect_pc=24'hFFFFFF -> if_pc=24'hFFFFFF, if_pc_plus1=24'h000000; following fetch addr 24'h000000.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared processor constants and the fetch-stage state encoding.
package proc_pkg;

  localparam int INSTR_W = 34;
  localparam int ADDR_W  = 24;
  localparam logic [ADDR_W-1:0] RESET_PC = 24'h0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/pc_register.sv
// Program counter: async reset to RESET_PC, redirect load wins over fetch increment.
module pc_register #(
  parameter int ADDR_W = proc_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = proc_pkg::RESET_PC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_loadPc,
  input  logic              i_inc,
  output logic [ADDR_W-1:0] o_pc
);

  logic [ADDR_W-1:0] r_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (i_load) begin
      r_pc <= i_loadPc;
    end else if (i_inc) begin
      r_pc <= r_pc + ADDR_W'(1);
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: one outstanding imem read, IF/ID register with ready/valid
// handshake, and branch redirect that flushes or discards the in-flight fetch.
module fetch_stage #(
  parameter int INSTR_W = proc_pkg::INSTR_W,
  parameter int ADDR_W  = proc_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = proc_pkg::RESET_PC
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [ADDR_W-1:0]  if_pc_plus1
);

  import proc_pkg::*;

  fetch_state_t      r_state;
  fetch_state_t      w_nextState;
  logic              r_started;
  logic [ADDR_W-1:0] r_issAddr;
  logic [ADDR_W-1:0] w_pc;
  logic              w_outFree;
  logic              w_issue;
  logic              w_accept;

  // Issuing only when the IF/ID register is empty or draining means a response never finds it full.
  assign w_outFree = !if_valid || if_ready;
  assign w_issue   = r_started && (r_state == IDLE) && !redirect_valid && w_outFree;
  assign w_accept  = (r_state == WAIT) && imem_rvalid && !redirect_valid;

  assign imem_req  = w_issue;
  assign imem_addr = w_issue ? w_pc : '0;

  pc_register #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pcReg (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (redirect_valid),
    .i_loadPc (redirect_pc),
    .i_inc    (w_issue),
    .o_pc     (w_pc)
  );

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_issue) w_nextState = WAIT;
      end
      WAIT: begin
        if (imem_rvalid)         w_nextState = IDLE;
        else if (redirect_valid) w_nextState = DISCARD;
      end
      DISCARD: begin
        if (imem_rvalid) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // r_started holds off the first issue until the edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_started <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_started <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_issAddr <= '0;
    end else if (w_issue) begin
      r_issAddr <= w_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_valid    <= 1'b0;
      if_instr    <= '0;
      if_pc       <= '0;
      if_pc_plus1 <= '0;
    end else if (w_accept) begin
      if_valid    <= 1'b1;
      if_instr    <= imem_rdata;
      if_pc       <= r_issAddr;
      if_pc_plus1 <= r_issAddr + ADDR_W'(1);
    end else if (redirect_valid || if_ready) begin
      if_valid    <= 1'b0;
    end
  end

endmodule
